// File: rtl/fetch_control_pkg.sv
// Shared types and default constants for the instruction-fetch controller.
package fetch_control_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned ILEN         = 32;

    localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [ILEN-1:0]         NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        FETCH      = 2'd1,
        REDIR_WAIT = 2'd2,
        HOLD       = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic            valid;
    } skid_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched instruction that IF/ID could not accept yet.
module fetch_skid_buf
    import fetch_control_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic            unload,
    input  logic [ILEN-1:0] din,
    output skid_entry_t     entry
);

    // Discard wins over capture so a flush always leaves the buffer empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entry <= '0;
        end else if (clear) begin
            entry <= '0;
        end else if (load) begin
            entry <= '{instr: din, valid: 1'b1};
        end else if (unload) begin
            entry <= '0;
        end
    end

endmodule

// File: rtl/fetch_control.sv
// Instruction-fetch sequencer: owns the PC, runs the imem request handshake and
// writes the IF/ID register with stall, flush and redirect handling.
module fetch_control
    import fetch_control_pkg::*;
#(
    parameter int unsigned      XLEN      = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [ILEN-1:0]  NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            hazard_stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [ILEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic [ILEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_npc,
    output logic            ifid_valid,
    output logic [31:0]     fetch_count
);

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] pending, pending_nxt;
    logic [ILEN-1:0] instr_nxt;
    logic [XLEN-1:0] npc_nxt;
    logic            valid_nxt;
    logic [31:0]     count_nxt;
    logic            req_nxt;

    logic            skid_load, skid_clear, skid_unload;
    skid_entry_t     skid;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target_aligned;

    assign pc_plus4       = pc + XLEN'(4);
    assign target_aligned = {branch_target[XLEN-1:2], 2'b00};

    // The address is only ever changed by pc, so it stays stable across a wait.
    assign imem_addr = pc;
    assign pc_out    = pc;

    fetch_skid_buf u_skid (
        .clock  (clock),
        .reset  (reset),
        .load   (skid_load),
        .clear  (skid_clear),
        .unload (skid_unload),
        .din    (imem_rdata),
        .entry  (skid)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            pending     <= '0;
            imem_req    <= 1'b0;
            ifid_instr  <= NOP_INSTR;
            ifid_npc    <= '0;
            ifid_valid  <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pending     <= pending_nxt;
            imem_req    <= req_nxt;
            ifid_instr  <= instr_nxt;
            ifid_npc    <= npc_nxt;
            ifid_valid  <= valid_nxt;
            fetch_count <= count_nxt;
        end
    end

    // Next-state and next-output logic; priority is flush > stall > advance.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pending_nxt = pending;
        instr_nxt   = ifid_instr;
        npc_nxt     = ifid_npc;
        valid_nxt   = ifid_valid;
        count_nxt   = fetch_count;
        skid_load   = 1'b0;
        skid_clear  = 1'b0;
        skid_unload = 1'b0;

        case (state)
            BOOT: begin
                state_nxt = FETCH;
            end

            FETCH: begin
                if (branch_taken) begin
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                    if (imem_ready) begin
                        pc_nxt = target_aligned;
                    end else begin
                        pending_nxt = target_aligned;
                        state_nxt   = REDIR_WAIT;
                    end
                end else if (imem_ready) begin
                    if (hazard_stall) begin
                        skid_load = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        instr_nxt = imem_rdata;
                        npc_nxt   = pc_plus4;
                        valid_nxt = 1'b1;
                        pc_nxt    = pc_plus4;
                        count_nxt = fetch_count + 32'd1;
                    end
                end else if (!hazard_stall) begin
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                end
            end

            REDIR_WAIT: begin
                instr_nxt = NOP_INSTR;
                valid_nxt = 1'b0;
                if (imem_ready) begin
                    pc_nxt    = branch_taken ? target_aligned : pending;
                    state_nxt = FETCH;
                end else if (branch_taken) begin
                    pending_nxt = target_aligned;
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    skid_clear = 1'b1;
                    pc_nxt     = target_aligned;
                    instr_nxt  = NOP_INSTR;
                    valid_nxt  = 1'b0;
                    state_nxt  = FETCH;
                end else if (!hazard_stall) begin
                    skid_unload = 1'b1;
                    instr_nxt   = skid.instr;
                    npc_nxt     = pc_plus4;
                    valid_nxt   = skid.valid;
                    pc_nxt      = pc_plus4;
                    count_nxt   = fetch_count + 32'd1;
                    state_nxt   = FETCH;
                end
            end

            default: begin
                state_nxt = BOOT;
            end
        endcase

        req_nxt = (state_nxt == FETCH) || (state_nxt == REDIR_WAIT);
    end

endmodule
